// File: rtl/avalon_mem_pkg.sv
// Shared types and helpers for the wait-state Avalon-MM memory.
// Byte-merge is used by the storage array write port.
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

  localparam int unsigned BYTE_LANES    = 4;
  localparam int unsigned WORD_ADDR_LSB = 2;

  function automatic logic [31:0] be_merge(input logic [31:0]           old_word,
                                           input logic [31:0]           new_word,
                                           input logic [BYTE_LANES-1:0] be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(BYTE_LANES); i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// WORDS x 32 storage: one byte-enabled synchronous write port, one combinational read port.
// Asynchronous clear zeroes every word; no backpressure.
module mem_word_array
  import avalon_mem_pkg::*;
#(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [BYTE_LANES-1:0] be_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WORDS); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= be_merge(mem_q[waddr_i], wdata_i, be_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/avalon_wait_mem.sv
// Avalon-MM slave memory with WAIT_CYCLES programmable wait states and a side-band preload port.
// Transfer takes WAIT_CYCLES+2 cycles; waitrequest holds the master until the ACK cycle.
module avalon_wait_mem
  import avalon_mem_pkg::*;
#(
  parameter int unsigned WORDS       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [BYTE_LANES-1:0] byteenable,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  input  logic                  inst_input,
  input  logic [7:0]            inst_addr,
  input  logic [31:0]           instruction
);

  localparam int unsigned AW        = $clog2(WORDS);
  localparam logic [31:0] SPAN      = 32'(BYTE_LANES * WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_t state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic                  is_rd_q, is_rd_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  enter_ack;

  logic [31:0]           lk_addr, lk_off;
  logic                  lk_in_range, bus_we, arr_we;
  logic [AW-1:0]         arr_waddr, arr_raddr;
  logic [31:0]           arr_wdata, arr_rdata;
  logic [BYTE_LANES-1:0] arr_be;
  logic                  unused_inst_lsb;

  // With zero wait states the capture and the ACK entry share an edge, so look up the live address.
  assign lk_addr     = (state_q == IDLE) ? address : addr_q;
  assign lk_off      = lk_addr - BASE_ADDR;
  assign lk_in_range = lk_off < SPAN;
  assign arr_raddr   = lk_off[WORD_ADDR_LSB +: AW];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    is_rd_d     = is_rd_q;
    rdata_d     = rdata_q;
    enter_ack   = 1'b0;
    waitrequest = 1'b0;
    unique case (state_q)
      IDLE: begin
        waitrequest = read | write;
        if ((read | write) && !inst_input) begin
          addr_d    = address;
          wdata_d   = writedata;
          be_d      = byteenable;
          is_rd_d   = read;
          cnt_d     = WAIT_INIT;
          state_d   = (WAIT_CYCLES == 0) ? ACK : WAIT;
          enter_ack = (WAIT_CYCLES == 0);
        end
      end
      WAIT: begin
        waitrequest = 1'b1;
        if (!read && !write) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (enter_ack && is_rd_d) rdata_d = lk_in_range ? arr_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_rd_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_rd_q <= is_rd_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;

  // The bus write owns the array port in its ACK cycle; preload uses it otherwise.
  assign bus_we    = (state_q == ACK) && !is_rd_q && lk_in_range;
  assign arr_we    = bus_we | inst_input;
  assign arr_waddr = bus_we ? lk_off[WORD_ADDR_LSB +: AW] : AW'(inst_addr[7:2]);
  assign arr_wdata = bus_we ? wdata_q : instruction;
  assign arr_be    = bus_we ? be_q : '1;

  assign unused_inst_lsb = ^inst_addr[1:0];

  mem_word_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_avalon_wait_mem.sv
// Bench for avalon_wait_mem: a 2-wait-state instance and a 0-wait-state instance against an array model.
module tb_avalon_wait_mem;

  localparam int unsigned W2   = 2;
  localparam int unsigned W0   = 0;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        read, write, inst_input;
  logic [31:0] address, writedata, instruction;
  logic [3:0]  byteenable;
  logic [7:0]  inst_addr;

  logic        r2, w2, ii2, r0, w0, ii0;
  logic        wr2, wr0, cur_wr;
  logic [31:0] rd2, rd0, cur_rd;

  logic [31:0] mem_m [2][256];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign r2  = read & ~sel;
  assign w2  = write & ~sel;
  assign ii2 = inst_input & ~sel;
  assign r0  = read & sel;
  assign w0  = write & sel;
  assign ii0 = inst_input & sel;
  assign cur_wr = sel ? wr0 : wr2;
  assign cur_rd = sel ? rd0 : rd2;

  avalon_wait_mem #(.WORDS(256), .WAIT_CYCLES(W2), .BASE_ADDR(BASE)) dut2 (
    .clk(clk), .reset(reset), .address(address), .read(r2), .write(w2),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wr2), .readdata(rd2),
    .inst_input(ii2), .inst_addr(inst_addr), .instruction(instruction)
  );

  avalon_wait_mem #(.WORDS(256), .WAIT_CYCLES(W0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .address(address), .read(r0), .write(w0),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wr0), .readdata(rd0),
    .inst_input(ii0), .inst_addr(inst_addr), .instruction(instruction)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) mem_m[s][i] = 32'h0;
  endtask

  // Samples at each negedge until waitrequest drops, then releases the request after ACK.
  task automatic wait_ack(output logic [31:0] rdat, output int nw);
    nw = 0;
    @(negedge clk);
    while (cur_wr && nw < 100) begin
      nw++;
      @(negedge clk);
    end
    rdat = cur_rd;
    @(posedge clk); #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic xfer(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, output logic [31:0] rdat);
    int nw;
    int s;
    logic [31:0] off;
    s = sel ? 1 : 0;
    @(posedge clk); #1;
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    wait_ack(rdat, nw);
    chk({tag, "_wait"}, 32'(nw), 32'((sel ? W0 : W2) + 1));
    off = a - BASE;
    if (rd) begin
      chk({tag, "_rdata"}, rdat, (off < 32'd1024) ? mem_m[s][off[9:2]] : 32'h0);
    end else if (off < 32'd1024) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[s][off[9:2]][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    inst_input = 1'b1; inst_addr = a; instruction = d;
    @(posedge clk); #1;
    inst_input = 1'b0;
    mem_m[sel ? 1 : 0][a[7:2]] = d;
  endtask

  task automatic sweep(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) xfer("sweep", 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0, r);
  endtask

  initial begin
    logic [31:0] r;
    int nw;
    int kind;
    logic [31:0] a;

    sel = 1'b0; read = 1'b0; write = 1'b0; inst_input = 1'b0;
    address = '0; writedata = '0; byteenable = '0; inst_addr = '0; instruction = '0;
    clear_model();
    reset = 1'b0;
    #12;
    chk("rst_wait", 32'(wr2), 32'h0);
    chk("rst_rdata", rd2, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    preload(8'h04, 32'h2402A234);
    xfer("pl_rd04", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, r);
    chk("pl_rd04_const", r, 32'h2402A234);

    preload(8'h08, 32'h00021203);
    xfer("be_wr08", 1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, r);
    xfer("be_rd08", 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, r);
    chk("be_rd08_const", r, 32'h00BB12DD);

    @(posedge clk); #1;
    write = 1'b1; address = 32'h0C; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
    @(negedge clk);
    chk("abort_idle_req", 32'(wr2), 32'h1);
    @(posedge clk); #1;
    write = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", 32'(wr2), 32'h1);
    @(negedge clk);
    chk("abort_back_idle", 32'(wr2), 32'h0);
    repeat (4) @(posedge clk);
    xfer("abort_rd0c", 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, r);
    chk("abort_rd0c_const", r, 32'h0);

    xfer("oor_rd", 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, r);
    chk("oor_rd_const", r, 32'h0);
    xfer("oor_wr", 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, r);
    sweep(256);

    @(posedge clk); #1;
    read = 1'b1; address = 32'h20;
    inst_input = 1'b1; inst_addr = 8'h20; instruction = 32'h8C220004;
    repeat (4) begin
      @(negedge clk);
      chk("pl_hold_wait", 32'(wr2), 32'h1);
      @(posedge clk);
    end
    #1;
    inst_input = 1'b0;
    mem_m[0][8] = 32'h8C220004;
    wait_ack(r, nw);
    chk("pl_hold_cycles", 32'(nw), 32'(W2 + 1));
    chk("pl_hold_rdata", r, 32'h8C220004);

    xfer("pre_rst_rd", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, r);
    @(posedge clk); #1;
    write = 1'b1; address = 32'h10; writedata = 32'h12345678; byteenable = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0; write = 1'b0;
    #2;
    chk("midrst_wait", 32'(wr2), 32'h0);
    chk("midrst_rdata", rd2, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_model();
    xfer("postrst_rd04", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, r);
    xfer("postrst_rd10", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, r);
    sweep(16);

    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 8) a = {23'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
      else a = 32'h400 + 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) < 8 && a < 32'h400) a = 32'($urandom_range(0, 127));
      if (kind <= 3)      xfer("rnd_rd", 1'b1, 1'b0, a, 32'h0, 4'h0, r);
      else if (kind <= 7) xfer("rnd_wr", 1'b0, 1'b1, a, $urandom(), 4'($urandom_range(0, 15)), r);
      else if (kind == 8) xfer("rnd_rw", 1'b1, 1'b1, a, $urandom(), 4'hF, r);
      else                preload(8'($urandom_range(0, 127)), $urandom());
    end
    sweep(64);

    sel = 1'b1;
    preload(8'h04, 32'hCAFEF00D);
    xfer("w0_rw04", 1'b1, 1'b1, 32'h04, 32'h11111111, 4'hF, r);
    chk("w0_rw04_const", r, 32'hCAFEF00D);
    xfer("w0_rd04", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, r);
    chk("w0_rd04_const", r, 32'hCAFEF00D);
    xfer("w0_wr04", 1'b0, 1'b1, 32'h04, 32'h55667788, 4'b1100, r);
    xfer("w0_rd04b", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, r);
    chk("w0_rd04b_const", r, 32'h5566F00D);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_wait_mem.md
# avalon_wait_mem

Avalon-MM slave memory directly downstream of `top_level_cpu`. It serves instruction fetches and data loads/stores over the CPU's bus master port and inserts a programmable number of wait states through `waitrequest`. It also provides a side-band preload port, so benches can write a program image before or while the CPU runs.

## Interface
- `WORDS`, 256: memory depth in 32-bit words (power of two).
- `WAIT_CYCLES`, 2: WAIT-state cycles per transfer (0..15).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `address`  in  32  byte address from CPU; bits [1:0] ignored.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  store data.
- `byteenable`  in  4  lane enables for writes; bit i selects bits [8i+7:8i].
- `waitrequest`  out  1  high = transfer not yet accepted.
- `readdata`  out  32  read data, valid in the ACK cycle.
- `inst_input`  in  1  preload enable.
- `inst_addr`  in  8  preload byte address, relative to `BASE_ADDR`.
- `instruction`  in  32  preload word.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - `read|write` high and `inst_input` low: capture `address`, `writedata`, `byteenable` and the kind (read wins if both are high; write dropped).
  - Load counter with `WAIT_CYCLES`.
  - Go to WAIT, or straight to ACK if `WAIT_CYCLES`=0.
- WAIT:
  - Counter decrements each cycle; at 1, go to ACK.
  - If `read` and `write` are both low, abort to IDLE with no side effect.
- ACK: one cycle, then IDLE.
  - Read: `readdata` is the registered word captured on entry to ACK.
  - Write: the enabled bytes commit at the end of the ACK cycle.
- Range check on the captured address:
  - In range: `address - BASE_ADDR < 4*WORDS`.
  - Out of range: read returns 32'h0, write is dropped; the handshake still completes normally.
- `waitrequest` (combinational):
  - 1 in IDLE when `read|write` is high.
  - 1 in WAIT.
  - 0 in ACK.
  - 0 otherwise.
- Preload:
  - While `inst_input`=1, each rising edge writes `instruction` to word `inst_addr[7:2]` (all bytes).
  - The FSM holds in IDLE, so bus requests see `waitrequest`=1.
  - Preload and bus write never commit in the same cycle.
- Master holds `address`/`writedata` stable while `waitrequest`=1; the block uses only the captured copies.

## Timing
- Reset values: state IDLE, counter 0, `readdata` 32'h0, all words 32'h0, `waitrequest` follows its IDLE rule (0 with no request).
- Request asserted in cycle T: `waitrequest` is high for T..T+`WAIT_CYCLES` and low in cycle T+`WAIT_CYCLES`+1 (ACK).
- Transfer length is `WAIT_CYCLES`+2 cycles.
- Back-to-back requests: the next request is sampled in the IDLE cycle after ACK. There is at least one `waitrequest`=1 cycle per transfer.
- Write then read of the same word: the read returns the new data, since the commit precedes the next capture.
- Reset asserted mid-transfer:
  - Immediate return to IDLE.
  - Pending write discarded.
  - Memory cleared.
  - `readdata`=0.
- Counter width 4 bits; no wrap, since it only loads values ≤15.

## Structure
- Package `avalon_mem_pkg`:
  - `mem_state_t` enum (IDLE, WAIT, ACK).
  - Constants `BYTE_LANES`=4 and `WORD_ADDR_LSB`=2.
  - Function `be_merge(old, new, be)` returning the byte-merged word.
- Sub-module `mem_word_array`: `WORDS`×32 storage with one byte-enabled write port, one read port and asynchronous clear. The FSM, counter and preload mux live in the top module.

## Test plan
- Preload 0x04←32'h2402A234, then read 0x04 with `WAIT_CYCLES`=2 -> `waitrequest` high 3 cycles, low in 4th, `readdata`=32'h2402A234.
- Preload 0x08←32'h00021203, write 0x08 with data 32'hAABBCCDD and `byteenable`=4'b0101, then read 0x08 -> 32'h00BB12DD.
- Read 0x400 with `WORDS`=256 -> completes in `WAIT_CYCLES`+2 cycles with `readdata`=0; a write to 0x400 leaves every word unchanged.
- Start a write to 0x0C, drop `write` in the first WAIT cycle -> FSM returns to IDLE and word 0x0C stays 0. Repeat with `reset`=0 mid-WAIT -> all outputs at reset values, memory zeroed.
- `inst_input`=1 while `read` is held -> `waitrequest` stays 1 throughout preload; after `inst_input` falls the read completes `WAIT_CYCLES`+2 cycles later with the preloaded data.
- `WAIT_CYCLES`=0: read and write both high on 0x04 -> `waitrequest` high 1 cycle, ACK next cycle, read data returned, memory unchanged.
